pc_predict: RTL and testbench

PC_PREDICT -- requirements
Module: pc_predict

---
 rtl/pc_predict.sv | 106 ++++++++++
 tb/tb_pc_predict.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_predict.sv
// Fetch PC register with a direct-mapped branch target buffer.
// Each entry holds a 2-bit direction counter; predictions are read before the same cycle's training write.
module pc_predict #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned     BTB_DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_write,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic [XLEN-1:0] update_target,
    input  logic            update_taken,
    output logic [XLEN-1:0] current_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_next_pc
);

    localparam int unsigned IDX   = $clog2(BTB_DEPTH);
    localparam int unsigned TAG_W = XLEN - IDX - 2;

    logic [XLEN-1:0]      pc_q, pc_d;
    logic [BTB_DEPTH-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q [BTB_DEPTH];
    logic [TAG_W-1:0]     tag_d [BTB_DEPTH];
    logic [XLEN-1:0]      tgt_q [BTB_DEPTH];
    logic [XLEN-1:0]      tgt_d [BTB_DEPTH];
    logic [1:0]           ctr_q [BTB_DEPTH];
    logic [1:0]           ctr_d [BTB_DEPTH];

    logic [IDX-1:0]   lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;
    logic [1:0]       unused_upd_lsb;

    assign lk_idx         = pc_q[IDX+1:2];
    assign lk_tag         = pc_q[XLEN-1:IDX+2];
    assign up_idx         = update_pc[IDX+1:2];
    assign up_tag         = update_pc[XLEN-1:IDX+2];
    assign unused_upd_lsb = update_pc[1:0];

    // Lookup on the registered fetch PC only
    always_comb begin
        lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken   = lk_hit && ctr_q[lk_idx][1];
        pred_next_pc = pred_taken ? tgt_q[lk_idx] : pc_q + XLEN'(4);
    end

    assign current_pc = pc_q;

    // Next fetch PC: redirect wins over a normal advance
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (pc_write) begin
            pc_d = pred_next_pc;
        end
    end

    // Training of the entry addressed by the resolved instruction
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        if (update_valid) begin
            if (up_hit) begin
                if (update_taken) begin
                    tgt_d[up_idx] = update_target;
                    if (ctr_q[up_idx] != 2'b11) begin
                        ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
                    end
                end else if (ctr_q[up_idx] != 2'b00) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
                end
            end else if (update_taken) begin
                valid_d[up_idx] = 1'b1;
                tag_d[up_idx]   = up_tag;
                tgt_d[up_idx]   = update_target;
                ctr_d[up_idx]   = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            valid_q <= '0;
            tag_q   <= '{default: '0};
            tgt_q   <= '{default: '0};
            ctr_q   <= '{default: 2'b01};
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            ctr_q   <= ctr_d;
        end
    end

endmodule

// File: tb/tb_pc_predict.sv
// Bench for pc_predict: directed scenarios plus random traffic against a table-based reference model.
module tb_pc_predict;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned IDXB  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, pc_write, redirect_valid, update_valid, update_taken;
    logic [31:0] redirect_pc, update_pc, update_target;
    logic [31:0] current_pc, pred_next_pc;
    logic        pred_taken;

    always #5 clk = ~clk;

    pc_predict #(.XLEN(XLEN), .RESET_PC(RST_PC), .BTB_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_write      (pc_write),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .update_valid  (update_valid),
        .update_pc     (update_pc),
        .update_target (update_target),
        .update_taken  (update_taken),
        .current_pc    (current_pc),
        .pred_taken    (pred_taken),
        .pred_next_pc  (pred_next_pc)
    );

    // Reference model: entries addressed by plain arithmetic on the PC
    bit          m_valid [DEPTH];
    logic [31:0] m_tag   [DEPTH];
    logic [31:0] m_tgt   [DEPTH];
    int          m_ctr   [DEPTH];
    logic [31:0] m_pc;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % DEPTH);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / (4 * DEPTH);
    endfunction

    function automatic bit m_pred_taken();
        int i = idx_of(m_pc);
        return m_valid[i] && (m_tag[i] == tag_of(m_pc)) && (m_ctr[i] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_npc();
        logic [31:0] seq = m_pc + 32'd4;
        return m_pred_taken() ? m_tgt[idx_of(m_pc)] : seq;
    endfunction

    task automatic compare(input string t);
        check({t, "_pc"},  current_pc,           m_pc);
        check({t, "_pt"},  32'(pred_taken),      32'(m_pred_taken()));
        check({t, "_npc"}, pred_next_pc,         m_pred_npc());
    endtask

    // Advance model by one clock using the currently driven inputs, then clock the DUT
    task automatic tick();
        logic [31:0] npc;
        int i;
        if (!reset) begin
            m_pc = RST_PC;
            for (int k = 0; k < DEPTH; k++) begin
                m_valid[k] = 0; m_ctr[k] = 1; m_tgt[k] = '0; m_tag[k] = '0;
            end
        end else begin
            npc = m_pred_npc();
            if (redirect_valid)  npc = redirect_pc;
            else if (!pc_write)  npc = m_pc;
            if (update_valid) begin
                i = idx_of(update_pc);
                if (m_valid[i] && m_tag[i] == tag_of(update_pc)) begin
                    if (update_taken) begin
                        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                        m_tgt[i] = update_target;
                    end else begin
                        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                    end
                end else if (update_taken) begin
                    m_valid[i] = 1; m_tag[i] = tag_of(update_pc);
                    m_tgt[i] = update_target; m_ctr[i] = 2;
                end
            end
            m_pc = npc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b1; pc_write = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        update_valid = 1'b0; update_pc = '0; update_target = '0; update_taken = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        idle(); redirect_valid = 1'b1; redirect_pc = pc; tick(); idle();
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        idle(); update_valid = 1'b1; update_pc = pc; update_target = tgt; update_taken = tk; tick(); idle();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] hi = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'h0;
        return hi | (32'($urandom_range(0, 63)) << 2);
    endfunction

    initial begin
        idle();
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        check("rst_pc", current_pc, RST_PC);
        check("rst_pt", 32'(pred_taken), 32'd0);
        check("rst_npc", pred_next_pc, RST_PC + 32'd4);

        // Sequential advance
        pc_write = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            compare("adv");
            tick();
            check("adv_const", current_pc, 32'(4 * i));
        end
        tick();
        check("at_10", current_pc, 32'h10);

        // Stall, then redirect while stalled
        pc_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall", current_pc, 32'h10);
        end
        redirect_to(32'h200);
        check("redir", current_pc, 32'h200);

        // Allocate on taken, simultaneous with a redirect to the trained PC
        idle(); redirect_valid = 1'b1; redirect_pc = 32'h40;
        update_valid = 1'b1; update_pc = 32'h40; update_target = 32'h100; update_taken = 1'b1;
        tick(); idle();
        check("alloc_pc", current_pc, 32'h40);
        check("alloc_pt", 32'(pred_taken), 32'd1);
        check("alloc_npc", pred_next_pc, 32'h100);
        pc_write = 1'b1; tick(); idle();
        check("follow", current_pc, 32'h100);

        // Counter saturation and hysteresis
        train(32'h40, 32'h100, 1'b1);
        train(32'h40, 32'h100, 1'b1);
        train(32'h40, 32'h100, 1'b0);
        train(32'h40, 32'h100, 1'b0);
        redirect_to(32'h40);
        check("weaknt_npc", pred_next_pc, 32'h44);
        compare("weaknt");
        train(32'h40, 32'h100, 1'b1);
        check("weakt_npc", pred_next_pc, 32'h100);

        // Alias at same index, different tag
        train(32'h80, 32'h300, 1'b1);
        check("alias40_npc", pred_next_pc, 32'h44);
        redirect_to(32'h80);
        check("alias80_npc", pred_next_pc, 32'h300);
        idle(); update_valid = 1'b1; update_pc = 32'h80; update_taken = 1'b0;
        compare("rbw_same");
        check("rbw_old", pred_next_pc, 32'h300);
        tick(); idle();
        check("rbw_new", pred_next_pc, 32'h84);

        // Wrap at the top of the address space
        redirect_to(32'hFFFF_FFFC);
        check("wrap_npc", pred_next_pc, 32'h0);
        pc_write = 1'b1; tick(); idle();
        check("wrap_pc", current_pc, 32'h0);

        // Reset during redirect and training discards both
        idle(); reset = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h500;
        update_valid = 1'b1; update_pc = 32'h0; update_target = 32'h700; update_taken = 1'b1;
        tick(); idle();
        check("mid_rst_pc", current_pc, RST_PC);
        check("mid_rst_pt", 32'(pred_taken), 32'd0);
        check("mid_rst_npc", pred_next_pc, RST_PC + 32'd4);
        redirect_to(32'h80);
        check("flushed80", 32'(pred_taken), 32'd0);
        redirect_to(32'h40);
        check("flushed40", 32'(pred_taken), 32'd0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            reset          = ($urandom_range(0, 99) != 0);
            pc_write       = 1'($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 7) == 0) || (current_pc > 32'h400 && current_pc < 32'h8000_0000);
            redirect_pc    = rand_addr();
            update_valid   = 1'($urandom_range(0, 1));
            update_pc      = rand_addr() | 32'($urandom_range(0, 3));
            update_target  = rand_addr();
            update_taken   = 1'($urandom_range(0, 2) != 0);
            compare("rnd");
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
